// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants for the UART command receiver: word geometry, ASCII codes,
// FSM state encodings and the byte classification helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_cmd_rx_pkg;

  // Default data-path geometry: one 16-bit word, four hex digits.
  localparam int seq_dp_width = 16;
  localparam int uart_num_nib = 4;

  // ASCII codes used by the command grammar.
  localparam logic [7:0] ASC_W_UP  = 8'h57;  // 'W'
  localparam logic [7:0] ASC_W_LO  = 8'h77;  // 'w'
  localparam logic [7:0] ASC_COLON = 8'h3A;  // ':'
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_0     = 8'h30;  // '0'
  localparam logic [7:0] ASC_3     = 8'h33;  // '3'

  // Parser state encodings.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REG   = 3'd1;
  localparam logic [2:0] ST_COLON = 3'd2;
  localparam logic [2:0] ST_NIB   = 3'd3;
  localparam logic [2:0] ST_TERM  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  // Result of decoding one ASCII hex digit.
  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } hex_nib_t;

  // Map '0'-'9', 'A'-'F', 'a'-'f' to a nibble; vld is low for anything else.
  // Letters share their low nibble between cases ('A'=0x41, 'a'=0x61), so
  // adding 9 to the low nibble yields 10..15 for both.
  function automatic hex_nib_t hex_decode(input logic [7:0] c);
    hex_nib_t r;
    r.vld = 1'b1;
    r.nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.nib = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r.nib = c[3:0] + 4'd9;
    end else begin
      r.vld = 1'b0;
    end
    return r;
  endfunction

  // CR and LF both end a command line.
  function automatic logic is_term(input logic [7:0] c);
    return (c == ASC_CR) || (c == ASC_LF);
  endfunction

  // Register-index digit '0'..'3'.
  function automatic logic is_reg_digit(input logic [7:0] c);
    return (c >= ASC_0) && (c <= ASC_3);
  endfunction

  // 8-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_rx.sv
// ASCII write-command parser ("Wr:hhhh<CR|LF>") fed by a UART receiver byte stream.
// Write/error strobes are registered: they appear one cycle after the terminator byte.
// No backpressure: every i_rx_valid byte is consumed in its cycle. Optional echo: UART_CMD_ECHO_EN.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int DP_WIDTH = seq_dp_width,
  parameter int NUM_NIB  = uart_num_nib
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_wr_stb,
  output logic [1:0]          o_wr_reg,
  output logic [DP_WIDTH-1:0] o_wr_data,
  output logic                o_err,
  output logic [7:0]          o_err_cnt,
  output logic [7:0]          o_echo_data,
  output logic                o_echo_stb
);

  localparam int                CNT_W    = $clog2(NUM_NIB + 1);
  localparam logic [CNT_W-1:0]  LAST_NIB = CNT_W'(NUM_NIB - 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [1:0]          reg_idx;
  logic [DP_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]    nib_cnt;

  logic                fire_wr;
  logic                fire_err;
  logic                load_reg;
  logic                clr_data;
  logic                shift_en;

  hex_nib_t            hex;
  logic                term;
  logic                is_w;

  assign hex  = hex_decode(i_rx_data);
  assign term = is_term(i_rx_data);
  assign is_w = (i_rx_data == ASC_W_UP) || (i_rx_data == ASC_W_LO);

  // Next-state and action decode; nothing moves unless a byte is presented.
  always_comb begin
    state_nxt = state;
    fire_wr   = 1'b0;
    fire_err  = 1'b0;
    load_reg  = 1'b0;
    clr_data  = 1'b0;
    shift_en  = 1'b0;
    if (i_rx_valid) begin
      case (state)
        ST_IDLE: begin
          // Blank lines (stray CR/LF) are harmless and silently skipped.
          if (is_w) begin
            state_nxt = ST_REG;
          end else if (!term) begin
            state_nxt = ST_ERR;
          end
        end
        ST_REG: begin
          if (term) begin
            fire_err  = 1'b1;
            state_nxt = ST_IDLE;
          end else if (is_reg_digit(i_rx_data)) begin
            load_reg  = 1'b1;
            state_nxt = ST_COLON;
          end else begin
            state_nxt = ST_ERR;
          end
        end
        ST_COLON: begin
          if (term) begin
            fire_err  = 1'b1;
            state_nxt = ST_IDLE;
          end else if (i_rx_data == ASC_COLON) begin
            clr_data  = 1'b1;
            state_nxt = ST_NIB;
          end else begin
            state_nxt = ST_ERR;
          end
        end
        ST_NIB: begin
          if (term) begin
            fire_err  = 1'b1;
            state_nxt = ST_IDLE;
          end else if (hex.vld) begin
            shift_en = 1'b1;
            if (nib_cnt == LAST_NIB) begin
              state_nxt = ST_TERM;
            end
          end else begin
            state_nxt = ST_ERR;
          end
        end
        ST_TERM: begin
          // Only a terminator is legal here; a surplus digit spoils the line.
          if (term) begin
            fire_wr   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_ERR;
          end
        end
        ST_ERR: begin
          // Swallow the rest of a bad line, report it once at its end.
          if (term) begin
            fire_err  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Parser state, captured register index and the hex shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      reg_idx <= 2'd0;
      shift_q <= '0;
      nib_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_reg) begin
        reg_idx <= i_rx_data[1:0];
      end
      if (clr_data) begin
        shift_q <= '0;
        nib_cnt <= '0;
      end else if (shift_en) begin
        shift_q <= {shift_q[DP_WIDTH-5:0], hex.nib};
        nib_cnt <= nib_cnt + 1'b1;
      end
    end
  end

  // Registered command outputs; reg/data are only refreshed by a good command.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wr_stb  <= 1'b0;
      o_err     <= 1'b0;
      o_wr_reg  <= 2'd0;
      o_wr_data <= '0;
      o_err_cnt <= 8'd0;
    end else begin
      o_wr_stb <= fire_wr;
      o_err    <= fire_err;
      if (fire_wr) begin
        o_wr_reg  <= reg_idx;
        o_wr_data <= shift_q;
      end
      if (fire_err) begin
        o_err_cnt <= sat_inc8(o_err_cnt);
      end
    end
  end

`ifdef UART_CMD_ECHO_EN
  // Loop every received byte back to the transmit side one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_echo_stb  <= 1'b0;
      o_echo_data <= 8'd0;
    end else begin
      o_echo_stb <= i_rx_valid;
      if (i_rx_valid) begin
        o_echo_data <= i_rx_data;
      end
    end
  end
`else
  // Echo path not built: keep the ports, tie them off.
  assign o_echo_stb  = 1'b0;
  assign o_echo_data = 8'd0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: spec vectors, reset/saturation sequences, and random
// command streams checked cycle by cycle against a line-buffer reference model.
// Define UART_CMD_ECHO_EN for both bench and RTL to exercise the echo path.
module tb_uart_cmd_rx;

  typedef logic [7:0] u8;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        o_wr_stb;
  logic [1:0]  o_wr_reg;
  logic [15:0] o_wr_data;
  logic        o_err;
  logic [7:0]  o_err_cnt;
  logic [7:0]  o_echo_data;
  logic        o_echo_stb;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen = 0;
  int err_seen = 0;
  int fail_prints = 0;
  bit mon_en = 1'b0;

  uart_cmd_rx dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_wr_stb    (o_wr_stb),
    .o_wr_reg    (o_wr_reg),
    .o_wr_data   (o_wr_data),
    .o_err       (o_err),
    .o_err_cnt   (o_err_cnt),
    .o_echo_data (o_echo_data),
    .o_echo_stb  (o_echo_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Bytes of the current line are buffered; at a terminator the whole line is
  // judged at once: empty -> nothing, well-formed -> write, otherwise -> error.
  u8           line_q[$];
  logic        m_stb = 1'b0;
  logic        m_err = 1'b0;
  logic [1:0]  m_reg = 2'd0;
  logic [15:0] m_data = 16'd0;
  logic [7:0]  m_cnt = 8'd0;
  logic        m_echo_stb = 1'b0;
  logic [7:0]  m_echo_data = 8'd0;

  function automatic int hexval(input u8 c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic bit parse_line(input u8 q[$], output logic [1:0] r, output logic [15:0] d);
    int v;
    r = 2'd0;
    d = 16'd0;
    if (q.size() != 7) return 1'b0;
    if (q[0] != 8'h57 && q[0] != 8'h77) return 1'b0;
    if (q[1] < 8'h30 || q[1] > 8'h33) return 1'b0;
    if (q[2] != 8'h3A) return 1'b0;
    r = 2'(int'(q[1]) - 48);
    for (int i = 3; i < 7; i++) begin
      v = hexval(q[i]);
      if (v < 0) return 1'b0;
      d = 16'(int'(d) * 16 + v);
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic [1:0]  r;
    logic [15:0] d;
    m_stb      = 1'b0;
    m_err      = 1'b0;
    m_echo_stb = 1'b0;
    if (rst) begin
      line_q.delete();
      m_reg       = 2'd0;
      m_data      = 16'd0;
      m_cnt       = 8'd0;
      m_echo_data = 8'd0;
    end else if (rx_valid) begin
`ifdef UART_CMD_ECHO_EN
      m_echo_stb  = 1'b1;
      m_echo_data = rx_data;
`endif
      if (rx_data == 8'h0D || rx_data == 8'h0A) begin
        if (line_q.size() > 0) begin
          if (parse_line(line_q, r, d)) begin
            m_stb  = 1'b1;
            m_reg  = r;
            m_data = d;
          end else begin
            m_err = 1'b1;
            if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
          end
        end
        line_q.delete();
      end else begin
        line_q.push_back(rx_data);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (o_wr_stb === 1'b1) wr_seen++;
    if (o_err === 1'b1) err_seen++;
    if (mon_en) begin
      n_tests++;
      if ({o_wr_stb, o_err, o_wr_reg, o_wr_data, o_err_cnt, o_echo_stb, o_echo_data} !==
          {m_stb, m_err, m_reg, m_data, m_cnt, m_echo_stb, m_echo_data}) begin
        n_fail++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL cycle_check t=%0t stb=%b exp %b err=%b exp %b reg=%0d exp %0d data=%h exp %h cnt=%0d exp %0d echo=%b/%h exp %b/%h",
                   $time, o_wr_stb, m_stb, o_err, m_err, o_wr_reg, m_reg, o_wr_data, m_data,
                   o_err_cnt, m_cnt, o_echo_stb, o_echo_data, m_echo_stb, m_echo_data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_q(input u8 q[$], input int maxgap);
    int g;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = q[i];
      g = int'($urandom_range(0, maxgap));
      repeat (g) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int maxgap);
    u8 q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
    send_q(q, maxgap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic u8 hexch(input int v, input bit lower);
    if (v < 10) return 8'(48 + v);
    return lower ? 8'(87 + v) : 8'(55 + v);
  endfunction

  task automatic check_counts(input string name, input int dwr, input int ewr,
                              input int derr, input int eerr);
    n_tests++;
    if (dwr != ewr || derr != eerr) begin
      n_fail++;
      $display("FAIL %s wr_pulses=%0d exp %0d err_pulses=%0d exp %0d", name, dwr, ewr, derr, eerr);
    end
  endtask

  // ---------------- spec vector table ----------------
  typedef struct {
    bit          do_rst;
    int          gap;
    int          exp_wr;
    int          exp_err;
    logic [1:0]  exp_reg;
    logic [15:0] exp_data;
    logic [7:0]  exp_cnt;
  } vec_t;

  localparam int NV = 9;
  vec_t  vec[NV];
  string stim[NV];

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, e0, kind, n;
    u8  q[$];

    stim[0] = "W2:BEEF\015";    vec[0] = '{0, 2, 1, 0, 2'd2, 16'hBEEF, 8'd0};
    stim[1] = "w1:a5c3\n";      vec[1] = '{0, 0, 1, 0, 2'd1, 16'hA5C3, 8'd0};
    stim[2] = "W2:12\015";      vec[2] = '{0, 1, 0, 1, 2'd1, 16'hA5C3, 8'd1};
    stim[3] = "W0:0001\015";    vec[3] = '{0, 0, 1, 0, 2'd0, 16'h0001, 8'd1};
    stim[4] = "W4:0000\015";    vec[4] = '{1, 0, 0, 1, 2'd0, 16'h0000, 8'd1};
    stim[5] = "W1:12345\015";   vec[5] = '{0, 2, 0, 1, 2'd0, 16'h0000, 8'd2};
    stim[6] = "X\015";          vec[6] = '{0, 0, 0, 1, 2'd0, 16'h0000, 8'd3};
    stim[7] = "\015\n";         vec[7] = '{0, 0, 0, 0, 2'd0, 16'h0000, 8'd3};
    stim[8] = "w3:FfFf\015\n";  vec[8] = '{0, 0, 1, 0, 2'd3, 16'hFFFF, 8'd3};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state of every output.
    n_tests++;
    if ({o_wr_stb, o_err, o_wr_reg, o_wr_data, o_err_cnt, o_echo_stb, o_echo_data} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state outputs=%h exp 0",
               {o_wr_stb, o_err, o_wr_reg, o_wr_data, o_err_cnt, o_echo_stb, o_echo_data});
    end

    for (int i = 0; i < NV; i++) begin
      if (vec[i].do_rst) do_reset();
      w0 = wr_seen;
      e0 = err_seen;
      send_str(stim[i], vec[i].gap);
      repeat (2) @(negedge clk);
      check_counts($sformatf("vec%0d_pulses", i), wr_seen - w0, vec[i].exp_wr,
                   err_seen - e0, vec[i].exp_err);
      n_tests++;
      if (o_wr_reg !== vec[i].exp_reg || o_wr_data !== vec[i].exp_data ||
          o_err_cnt !== vec[i].exp_cnt) begin
        n_fail++;
        $display("FAIL vec%0d_regs reg=%0d exp %0d data=%h exp %h cnt=%0d exp %0d", i,
                 o_wr_reg, vec[i].exp_reg, o_wr_data, vec[i].exp_data, o_err_cnt, vec[i].exp_cnt);
      end
    end

    // Reset in the middle of a command drops it; the tail is a bad line.
    do_reset();
    send_str("W3:AB", 0);
    do_reset();
    w0 = wr_seen;
    e0 = err_seen;
    send_str("CD\015", 0);
    repeat (2) @(negedge clk);
    check_counts("rst_mid_cmd", wr_seen - w0, 0, err_seen - e0, 1);
    n_tests++;
    if (o_err_cnt !== 8'd1 || o_wr_data !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid_cmd_regs cnt=%0d exp 1 data=%h exp 0000", o_err_cnt, o_wr_data);
    end

    // Randomised command stream, checked by the cycle monitor.
    for (int it = 0; it < 300; it++) begin
      q = {};
      q.push_back($urandom_range(0, 1) ? 8'h57 : 8'h77);
      q.push_back(8'(8'h30 + $urandom_range(0, 3)));
      q.push_back(8'h3A);
      for (int k = 0; k < 4; k++) q.push_back(hexch(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1))));
      kind = int'($urandom_range(0, 7));
      case (kind)
        3: q[$urandom_range(0, 6)] = 8'($urandom_range(32, 126));
        4: begin
          n = int'($urandom_range(0, 6));
          while (q.size() > n) void'(q.pop_back());
        end
        5: q.push_back($urandom_range(0, 1) ? hexch(int'($urandom_range(0, 15)), 1'b0)
                                            : 8'($urandom_range(32, 126)));
        6: begin
          q = {};
          n = int'($urandom_range(1, 10));
          for (int k = 0; k < n; k++) q.push_back(8'($urandom));
        end
        default: ;
      endcase
      if ($urandom_range(0, 29) == 0) begin
        send_q(q, 1);
        do_reset();
      end else begin
        q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
        send_q(q, int'($urandom_range(0, 2)));
      end
    end
    repeat (3) @(negedge clk);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) send_str("X\015", 0);
    repeat (2) @(negedge clk);
    n_tests++;
    if (o_err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL err_cnt_saturate cnt=%0d exp 255", o_err_cnt);
    end

    // A good command still goes through after saturation.
    w0 = wr_seen;
    e0 = err_seen;
    send_str("W1:C0DE\n", 0);
    repeat (2) @(negedge clk);
    check_counts("after_saturate", wr_seen - w0, 1, err_seen - e0, 0);
    n_tests++;
    if (o_wr_reg !== 2'd1 || o_wr_data !== 16'hC0DE || o_err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL after_saturate_regs reg=%0d exp 1 data=%h exp c0de cnt=%0d exp 255",
               o_wr_reg, o_wr_data, o_err_cnt);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
